// File: rtl/prco_ctrl.sv
// Multi-cycle sequencing controller for the PRCO core: fetch, decode, execute,
// memory and write-back sequencing around a single registered state machine.
module prco_ctrl #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              RET_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_halt,
    output logic [PC_W-1:0]  q_pc,
    output logic             q_imem_req,
    input  logic             i_imem_ack,
    input  logic [15:0]      i_imem_data,
    output logic [15:0]      q_instr,
    output logic             q_dec_en,
    input  logic             i_dec_reg_we,
    input  logic             i_dec_req_alu,
    input  logic             i_dec_req_ram,
    output logic             q_alu_start,
    input  logic             i_alu_done,
    output logic             q_ram_req,
    input  logic             i_ram_ack,
    output logic             q_reg_we,
    input  logic             i_jmp_valid,
    input  logic [PC_W-1:0]  i_jmp_addr,
    output logic             q_halted,
    output logic [2:0]       q_state,
    output logic [RET_W-1:0] q_retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [PC_W-1:0]  PC_ONE  = 1;
    localparam logic [RET_W-1:0] RET_ONE = 1;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [RET_W-1:0]  retired_q, retired_d;
    logic              reg_we_q, reg_we_d;
    logic              req_ram_q, req_ram_d;
    logic              exec_first_q, exec_first_d;

    logic imem_req, dec_en, alu_start, ram_req, reg_we_stb, halted;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            retired_q    <= '0;
            reg_we_q     <= 1'b0;
            req_ram_q    <= 1'b0;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            retired_q    <= retired_d;
            reg_we_q     <= reg_we_d;
            req_ram_q    <= req_ram_d;
            exec_first_q <= exec_first_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        retired_d    = retired_q;
        reg_we_d     = reg_we_q;
        req_ram_d    = req_ram_q;
        exec_first_d = 1'b0;
        imem_req     = 1'b0;
        dec_en       = 1'b0;
        alu_start    = 1'b0;
        ram_req      = 1'b0;
        reg_we_stb   = 1'b0;
        halted       = 1'b0;
        case (state_q)
            S_IDLE: state_d = i_halt ? S_HALT : S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (i_imem_ack) begin
                    instr_d = i_imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                dec_en       = 1'b1;
                exec_first_d = 1'b1;
                state_d      = S_EXEC;
            end
            S_EXEC: begin
                // Decoder flags are only trusted on the first EXEC cycle; keep a copy.
                if (exec_first_q) begin
                    reg_we_d  = i_dec_reg_we;
                    req_ram_d = i_dec_req_ram;
                    if (i_dec_req_alu) alu_start = 1'b1;
                    else               state_d   = i_dec_req_ram ? S_MEM : S_WB;
                end else if (i_alu_done) begin
                    state_d = req_ram_q ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                ram_req = 1'b1;
                if (i_ram_ack) state_d = S_WB;
            end
            S_WB: begin
                reg_we_stb = reg_we_q;
                pc_d       = i_jmp_valid ? i_jmp_addr : pc_q + PC_ONE;
                retired_d  = retired_q + RET_ONE;
                state_d    = i_halt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (!i_halt) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign q_pc        = pc_q;
    assign q_instr     = instr_q;
    assign q_retired   = retired_q;
    assign q_state     = state_q;
    assign q_imem_req  = imem_req;
    assign q_dec_en    = dec_en;
    assign q_alu_start = alu_start;
    assign q_ram_req   = ram_req;
    assign q_reg_we    = reg_we_stb;
    assign q_halted    = halted;

endmodule

// File: doc/prco_ctrl.md
Name: prco_ctrl

Overview:
- Multi-cycle sequencing controller for the PRCO core.
- Owns the program counter and fetches 16-bit instructions over a req/ack handshake.
- Drives the decoder enable, then uses the decoder's registered request flags (reg_we, req_alu, req_ram) to sequence ALU start/done, the RAM req/ack handshake and register-file write-back.
- Sits between instruction memory, prco_decoder, the ALU, data RAM and the register set.

Parameters:
PC_W, 16, program counter width; PC wraps modulo 2^PC_W
RESET_PC, 0, PC value loaded on reset
RET_W, 16, width of retired-instruction counter; wraps modulo 2^RET_W

Ports:
i_clk  in  1  core clock, all state updates on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_halt  in  1  pause request, sampled at instruction boundaries only
q_pc  out  PC_W  address of current instruction
q_imem_req  out  1  instruction fetch request
i_imem_ack  in  1  fetch acknowledge; i_imem_data valid same cycle
i_imem_data  in  16  fetched instruction
q_instr  out  16  latched instruction, feeds decoder i_instr
q_dec_en  out  1  decoder enable, one-cycle pulse
i_dec_reg_we  in  1  decoder register-write flag
i_dec_req_alu  in  1  decoder ALU-request flag
i_dec_req_ram  in  1  decoder RAM-request flag
q_alu_start  out  1  one-cycle ALU start pulse
i_alu_done  in  1  ALU completion
q_ram_req  out  1  data RAM request, held until ack
i_ram_ack  in  1  RAM acknowledge
q_reg_we  out  1  register-file write strobe, one cycle
i_jmp_valid  in  1  redirect PC, sampled in WB
i_jmp_addr  in  PC_W  redirect target
q_halted  out  1  high while in HALT
q_state  out  3  current state encoding, for debug
q_retired  out  RET_W  count of completed instructions

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is illegal and recovers to IDLE on the next clock.
- Reset (async, i_rst_n=0):
  - state=IDLE, q_pc=RESET_PC, q_instr=0, q_retired=0.
  - All strobes/requests (q_imem_req, q_dec_en, q_alu_start, q_ram_req, q_reg_we, q_halted) = 0.
  - Reset mid-handshake drops every request immediately; pending acks are ignored.
- IDLE: next = HALT if i_halt, else FETCH.
- FETCH:
  - q_imem_req=1 for every FETCH cycle.
  - On the cycle i_imem_ack=1: q_instr<=i_imem_data and next=DECODE.
  - Otherwise remain in FETCH; no timeout.
- DECODE:
  - q_dec_en=1 for exactly this one cycle.
  - The decoder's registered flags are valid from the first EXEC cycle.
- EXEC, first cycle:
  - Latch i_dec_reg_we/i_dec_req_alu/i_dec_req_ram into internal flags.
  - If req_alu: q_alu_start=1 this cycle only.
  - If no req_alu: next = MEM if req_ram, else WB.
- EXEC, with req_alu:
  - i_alu_done is honoured only from the second EXEC cycle onward; done in the first cycle is ignored.
  - On done: next = MEM if req_ram, else WB.
- MEM:
  - q_ram_req=1 each cycle until i_ram_ack=1, then next=WB.
  - Ack in the same cycle as MEM entry completes MEM in one cycle.
- WB:
  - q_reg_we = latched reg_we, this cycle only.
  - q_pc <= i_jmp_valid ? i_jmp_addr : q_pc+1; wraps at 2^PC_W-1 to 0.
  - q_retired <= q_retired+1, wrapping.
  - next = HALT if i_halt, else FETCH.
- HALT:
  - q_halted=1; no requests issued.
  - On i_halt=0: next=FETCH. q_pc is preserved.
- i_halt is ignored outside IDLE, WB and HALT; an in-flight instruction always completes.
- Outputs are decoded from the registered state and flags; a request never asserts in the same cycle as reset release.
- Minimum instruction latency, ack-in-first-cycle with no ALU/RAM: FETCH, DECODE, EXEC, WB = 4 cycles.
  - ALU-only with done on the second EXEC cycle: 5 cycles.
  - ALU plus RAM, each with immediate done/ack: 6 cycles.
- q_state reflects the current state every cycle.

Test Plan:
- Reset then release with i_halt=0, imem acking every request with 16'h1234 (no ALU/RAM, reg_we=1) -> IDLE for 1 cycle, then q_pc 0,1,2 advancing every 4 cycles; q_reg_we one pulse per instruction; q_retired=3 after 3 instructions.
- req_alu=1, i_alu_done held high from EXEC entry -> q_alu_start high exactly 1 cycle; done in the first EXEC cycle ignored; WB reached on the 2nd EXEC cycle.
- req_alu=1, req_ram=1, i_ram_ack delayed 3 cycles -> q_ram_req high for 4 consecutive cycles; WB on the next cycle; single q_reg_we pulse.
- PC_W=4, q_pc=15, no jump -> q_pc wraps to 0. i_jmp_valid=1 with i_jmp_addr=9 in WB -> next fetch at q_pc=9.
- i_halt raised during MEM -> instruction completes, state goes to HALT after WB, q_halted=1, no q_imem_req. i_halt dropped -> FETCH at the preserved PC.
- i_rst_n pulsed low during FETCH while q_imem_req=1 -> all outputs 0 immediately (asynchronously); q_pc=RESET_PC; an i_imem_ack arriving during reset is ignored.
